pat_gradient_anim: RTL and testbench
====================================

# pat_gradient_anim

Parametrised, animated successor to the team's static gradient pattern source. For each LED index requested by the strip driver it returns an RGB colour interpolated between two programmable endpoint colours. The gradient can be linear, mirrored, static or solid, and its phase advances on a frame tick so the pattern scrolls along the strip. It sits between the pattern-select mux and the LED serialiser and uses the same request/`color_valid` contract as the other pattern sources.

## Interface
Parameters:
- `NUM_LEDS`, 20, strip length; must be ≥ 2.
- `COLOR_WIDTH`, 8, bits per colour channel.
- `CounterWidth` (localparam), `$clog2(NUM_LEDS)`, LED index width.

Ports:
- `clk_in`, in, 1, single clock.
- `rst_in`, in, 1, reset; synchronous, active-high.
- `next_led_request`, in, `CounterWidth`, LED index whose colour is wanted; may change every cycle.
- `color_a_in`, in, `3*COLOR_WIDTH`, endpoint A packed `{R,G,B}`; colour at t=0.
- `color_b_in`, in, `3*COLOR_WIDTH`, endpoint B packed `{R,G,B}`; colour at t=1.
- `mode_in`, in, 2, pattern mode: 0 LINEAR, 1 MIRROR, 2 STATIC, 3 SOLID.
- `frame_tick_in`, in, 1, one-cycle pulse that advances the phase by one step.
- `speed_in`, in, `CounterWidth`, phase step per tick, in LEDs.
- `reverse_in`, in, 1, scroll direction: 1 subtracts the step instead of adding it.
- `red_out`, `green_out`, `blue_out`, out, `COLOR_WIDTH` each, interpolated colour.
- `color_valid`, out, 1, outputs correspond to the LED index currently on `next_led_request`.

## Operation
Phase register:
- `phase`, `CounterWidth` bits, range 0..NUM_LEDS-1. Resets to 0.
- On `frame_tick_in`, the effective step is `s = min(speed_in, NUM_LEDS-1)`.
- Forward: `phase = (phase + s) mod NUM_LEDS`. Reverse: `phase = (phase - s) mod NUM_LEDS`.
- Computed with one compare and one add/subtract, never a divider.

Pipeline, with one request accepted every cycle:
- S1: capture index `i`, `mode`, and endpoints. Position `p = (i + phase) mod NUM_LEDS`; in STATIC and SOLID, `p = i`.
- S2: fraction `t`, 17 bits, where `t = (p == NUM_LEDS-1) ? 65536 : p*RECIP` and `RECIP = round(65536/(NUM_LEDS-1))`.
  - MIRROR replaces t with `min(2t, 2*(65536-t))`.
  - SOLID forces `t = 0`.
- S3: per channel, `out = (a*(65536-t) + b*t) >> 16`. Endpoints are exact; the result is truncated and cannot overflow `COLOR_WIDTH`.

`color_valid`:
- Equals `valid_last && (idx_last == next_led_request)`.
- `idx_last` is the index travelling with the final stage.
- Combinational compare on a registered tag.

## Timing
Reset values:
- Colour outputs: 0.
- Pipeline valid bits: 0, so `color_valid` = 0.
- `phase`: 0.
- Index tags: 0.

Latency:
- 3 cycles from `next_led_request` to outputs, or 4 with gamma compiled in.
- A constant request yields `color_valid` = 1 from cycle 3 (or 4) onward.

Simultaneous events:
- Tick in the same cycle as a request: S1 uses the old phase; the new phase applies from the next cycle.
- `mode_in` and the endpoints are sampled in S1 per request. A mid-stream change affects only later requests.

Reset mid-operation:
- Flushes all valid bits and returns `phase` to 0 on the next edge.
- In-flight results are discarded.

## Configuration
- Macro: `PAT_GRADIENT_ANIM_GAMMA_EN`.
- Defined: adds a gamma stage S4 with `g = (x*(x+1)) >> COLOR_WIDTH` per channel. Effect: 0 stays 0, 255 stays 255, 128 becomes 64. Latency is 4.
- Undefined: S3 drives the outputs directly; latency is 3.

## Structure
- Shared `pat_pkg`:
  - `pat_mode_e` enum: LINEAR, MIRROR, STATIC, SOLID.
  - `FRAC_W = 16`.
  - `rgb_t` packed struct, parameterised by `COLOR_WIDTH` via a function or macro width.
- Sub-module `color_lerp`: single-channel S3 interpolation plus optional gamma. Instantiated three times.

## Test plan
All cases use NUM_LEDS=20, COLOR_WIDTH=8, A=(0,0,255), B=(0,255,0), gamma off unless stated.
- LINEAR, phase 0, requests 0, 10, 19, each held 4 cycles → RGB (0,0,255), (0,134,120), (0,255,0); `color_valid` rises exactly 3 cycles after each change.
- MIRROR, request 10 → (0,241,13). Requests 0 and 19 → (0,0,255).
- speed=1, one `frame_tick_in`, request 19 → (0,0,255) because p wraps to 0. With reverse=1 and 1 tick from reset, request 0 gives p=19 → (0,255,0).
- speed=25 → clamped to 19; one tick from phase 0 → phase 19. STATIC mode ignores phase: request 10 → (0,134,120).
- Request index changing every cycle → `color_valid` = 0 throughout. `rst_in` asserted mid-stream → next cycle all outputs 0, `color_valid` 0, phase 0.
- Gamma on, A=B=(128,0,255), SOLID → (64,0,255) at 4-cycle latency.

Source files
------------

// File: rtl/pat_pkg.sv
// Shared pattern-source types: mode encoding, fraction width and an RGB struct
// macro sized by the user's channel width.
`ifndef PAT_PKG_SV
`define PAT_PKG_SV

`define PAT_RGB_STRUCT(W) struct packed { logic [(W)-1:0] r; logic [(W)-1:0] g; logic [(W)-1:0] b; }

package pat_pkg;

  typedef enum logic [1:0] {
    LINEAR = 2'd0,
    MIRROR = 2'd1,
    STATIC = 2'd2,
    SOLID  = 2'd3
  } pat_mode_e;

  localparam int FRAC_W = 16;

  function automatic int rgb_width(input int color_width);
    return 3 * color_width;
  endfunction

endpackage

`endif

// File: rtl/color_lerp.sv
// One colour channel: fixed-point blend between two endpoints, plus an extra
// gamma stage when PAT_GRADIENT_ANIM_GAMMA_EN is defined.
module color_lerp
  import pat_pkg::*;
#(
  parameter int COLOR_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [COLOR_WIDTH-1:0] a_in,
  input  logic [COLOR_WIDTH-1:0] b_in,
  input  logic [FRAC_W:0]        t_in,
  output logic [COLOR_WIDTH-1:0] y_out
);

  localparam int AccW = COLOR_WIDTH + FRAC_W;
  localparam logic [FRAC_W:0] FracOne = (FRAC_W+1)'(1) << FRAC_W;

  logic [FRAC_W:0]        t_inv;
  logic [AccW-1:0]        acc;
  logic [COLOR_WIDTH-1:0] blend;

  // The weighted sum never exceeds max(a,b) * 2^FRAC_W, so AccW bits suffice.
  always_comb begin
    t_inv = FracOne - t_in;
    acc   = AccW'(a_in) * AccW'(t_inv) + AccW'(b_in) * AccW'(t_in);
    blend = acc[AccW-1:FRAC_W];
  end

`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
  logic [COLOR_WIDTH-1:0]   blend_q;
  logic [2*COLOR_WIDTH-1:0] sq;

  // x*(x+1) stays below 2^(2W), so full scale maps back onto full scale.
  always_comb begin
    sq = (2*COLOR_WIDTH)'(blend_q) * ((2*COLOR_WIDTH)'(blend_q) + (2*COLOR_WIDTH)'(1));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      blend_q <= '0;
      y_out   <= '0;
    end else begin
      blend_q <= blend;
      y_out   <= sq[2*COLOR_WIDTH-1:COLOR_WIDTH];
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst_in) y_out <= '0;
    else        y_out <= blend;
  end
`endif

endmodule

// File: rtl/pat_gradient_anim.sv
// Animated two-colour gradient pattern source with a scrolling phase.
// Optional gamma stage is compiled in with PAT_GRADIENT_ANIM_GAMMA_EN.
module pat_gradient_anim
  import pat_pkg::*;
#(
  parameter  int NUM_LEDS     = 20,
  parameter  int COLOR_WIDTH  = 8,
  localparam int CounterWidth = $clog2(NUM_LEDS)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [CounterWidth-1:0]       next_led_request,
  input  logic [rgb_width(COLOR_WIDTH)-1:0] color_a_in,
  input  logic [rgb_width(COLOR_WIDTH)-1:0] color_b_in,
  input  logic [1:0]                    mode_in,
  input  logic                          frame_tick_in,
  input  logic [CounterWidth-1:0]       speed_in,
  input  logic                          reverse_in,
  output logic [COLOR_WIDTH-1:0]        red_out,
  output logic [COLOR_WIDTH-1:0]        green_out,
  output logic [COLOR_WIDTH-1:0]        blue_out,
  output logic                          color_valid
);

  typedef `PAT_RGB_STRUCT(COLOR_WIDTH) rgb_t;

  localparam int CW = CounterWidth;
  localparam logic [CW:0]     NumLeds = (CW+1)'(NUM_LEDS);
  localparam logic [CW-1:0]   LastLed = CW'(NUM_LEDS - 1);
  localparam logic [FRAC_W:0] FracOne = (FRAC_W+1)'(1) << FRAC_W;
  // round(2^FRAC_W / (NUM_LEDS-1)) in integer arithmetic
  localparam logic [FRAC_W:0] Recip =
    (FRAC_W+1)'((2 * (2 ** FRAC_W) + NUM_LEDS - 1) / (2 * (NUM_LEDS - 1)));

  logic [CW-1:0] phase_q;
  logic [CW-1:0] step;
  logic [CW-1:0] phase_nx;
  logic [CW:0]   fwd_sum;
  logic [CW:0]   rev_diff;
  logic [CW:0]   pos_sum;
  logic [CW-1:0] pos;
  pat_mode_e     mode_req;

  always_comb begin
    step     = (speed_in > LastLed) ? LastLed : speed_in;
    fwd_sum  = {1'b0, phase_q} + {1'b0, step};
    rev_diff = {1'b0, phase_q} - {1'b0, step};
    if (reverse_in)
      phase_nx = rev_diff[CW] ? CW'(rev_diff + NumLeds) : rev_diff[CW-1:0];
    else
      phase_nx = (fwd_sum >= NumLeds) ? CW'(fwd_sum - NumLeds) : fwd_sum[CW-1:0];

    mode_req = pat_mode_e'(mode_in);
    pos_sum  = {1'b0, next_led_request} + {1'b0, phase_q};
    if (mode_req == STATIC || mode_req == SOLID)
      pos = next_led_request;
    else
      pos = (pos_sum >= NumLeds) ? CW'(pos_sum - NumLeds) : pos_sum[CW-1:0];
  end

  logic          v1, v2, v3;
  logic [CW-1:0] idx1, idx2, idx3;
  logic [CW-1:0] p1;
  pat_mode_e     mode1;
  rgb_t          a1, b1, a2, b2;
  logic [FRAC_W:0]   t2;
  logic [FRAC_W:0]   t_lin;
  logic [FRAC_W:0]   t_mode;
  logic [FRAC_W+1:0] t_dbl;
  logic [FRAC_W+1:0] t_back;

  // Last LED lands exactly on endpoint B instead of the rounded product.
  always_comb begin
    t_lin  = (p1 == LastLed) ? FracOne : (FRAC_W+1)'(p1) * Recip;
    t_dbl  = {t_lin, 1'b0};
    t_back = {FracOne - t_lin, 1'b0};
    case (mode1)
      MIRROR:  t_mode = (t_dbl < t_back) ? t_dbl[FRAC_W:0] : t_back[FRAC_W:0];
      SOLID:   t_mode = '0;
      default: t_mode = t_lin;
    endcase
  end

`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
  logic          v4;
  logic [CW-1:0] idx4;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_q <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      idx1    <= '0;
      idx2    <= '0;
      idx3    <= '0;
      p1      <= '0;
      mode1   <= LINEAR;
      a1      <= '0;
      b1      <= '0;
      a2      <= '0;
      b2      <= '0;
      t2      <= '0;
`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
      v4      <= 1'b0;
      idx4    <= '0;
`endif
    end else begin
      if (frame_tick_in) phase_q <= phase_nx;
      v1    <= 1'b1;
      idx1  <= next_led_request;
      p1    <= pos;
      mode1 <= mode_req;
      a1    <= color_a_in;
      b1    <= color_b_in;
      v2    <= v1;
      idx2  <= idx1;
      t2    <= t_mode;
      a2    <= a1;
      b2    <= b1;
      v3    <= v2;
      idx3  <= idx2;
`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
      v4    <= v3;
      idx4  <= idx3;
`endif
    end
  end

  color_lerp #(.COLOR_WIDTH(COLOR_WIDTH)) u_lerp_r (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a_in   (a2.r),
    .b_in   (b2.r),
    .t_in   (t2),
    .y_out  (red_out)
  );

  color_lerp #(.COLOR_WIDTH(COLOR_WIDTH)) u_lerp_g (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a_in   (a2.g),
    .b_in   (b2.g),
    .t_in   (t2),
    .y_out  (green_out)
  );

  color_lerp #(.COLOR_WIDTH(COLOR_WIDTH)) u_lerp_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a_in   (a2.b),
    .b_in   (b2.b),
    .t_in   (t2),
    .y_out  (blue_out)
  );

`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
  assign color_valid = v4 && (idx4 == next_led_request);
`else
  assign color_valid = v3 && (idx3 == next_led_request);
`endif

endmodule

// File: tb/tb_pat_gradient_anim.sv
// Bench for pat_gradient_anim: directed gradient cases plus randomized requests
// compared against an arithmetic model of the gradient rules.
module tb_pat_gradient_anim;

  localparam int N  = 20;
  localparam int W  = 8;
  localparam int CW = $clog2(N);
`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] req;
  logic [23:0]   col_a, col_b;
  logic [1:0]    mode;
  logic          tick;
  logic [CW-1:0] speed;
  logic          rev;
  logic [W-1:0]  red, green, blue;
  logic          cvalid;

  int total = 0;
  int bad = 0;
  int phase_m = 0;
  int last_req = -1;

  always #5 clk = ~clk;

  pat_gradient_anim #(.NUM_LEDS(N), .COLOR_WIDTH(W)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .next_led_request (req),
    .color_a_in       (col_a),
    .color_b_in       (col_b),
    .mode_in          (mode),
    .frame_tick_in    (tick),
    .speed_in         (speed),
    .reverse_in       (rev),
    .red_out          (red),
    .green_out        (green),
    .blue_out         (blue),
    .color_valid      (cvalid)
  );

  function automatic logic [23:0] model_rgb(int idx, int ph, int md, logic [23:0] a, logic [23:0] b);
    int     recip;
    longint p, t, ca, cb, x;
    logic [23:0] r;
    recip = $rtoi(65536.0 / real'(N - 1) + 0.5);
    p = (md >= 2) ? idx : (idx + ph) % N;
    t = (p == N - 1) ? 65536 : p * recip;
    if (md == 1) t = (2 * t < 2 * (65536 - t)) ? 2 * t : 2 * (65536 - t);
    if (md == 3) t = 0;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ca = longint'(a[c*8 +: 8]);
      cb = longint'(b[c*8 +: 8]);
      x  = (ca * (65536 - t) + cb * t) / 65536;
`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
      x  = (x * (x + 1)) / 256;
`endif
      r[c*8 +: 8] = x[7:0];
    end
    return r;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    int s;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    s = (int'(speed) > N - 1) ? N - 1 : int'(speed);
    phase_m = rev ? (phase_m - s + N) % N : (phase_m + s) % N;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    phase_m = 0;
    last_req = -1;
  endtask

  // Present a request, check valid stays low until the latency elapses, then check colour.
  task automatic req_check(string tag, int idx);
    logic changed;
    changed = (idx != last_req);
    req = CW'(idx);
    step(LAT - 1);
    if (changed) chk({tag, "_early"}, 32'(cvalid), 32'd0);
    step(1);
    chk({tag, "_valid"}, 32'(cvalid), 32'd1);
    chk({tag, "_rgb"}, {8'h0, red, green, blue},
        {8'h0, model_rgb(idx, phase_m, int'(mode), col_a, col_b)});
    last_req = idx;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    col_a = 24'h0000FF;
    col_b = 24'h00FF00;
    mode  = 2'd0;
    tick  = 1'b0;
    speed = '0;
    rev   = 1'b0;
    step(2);
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_valid", 32'(cvalid), 32'd0);
    rst = 1'b0;

    // LINEAR at phase 0
    req_check("lin0", 0);
    req_check("lin10", 10);
    req_check("lin19", 19);

    // MIRROR
    mode = 2'd1;
    req_check("mir10", 10);
    req_check("mir0", 0);
    req_check("mir19", 19);

    // forward scroll wraps the last LED back to endpoint A
    mode  = 2'd0;
    speed = CW'(1);
    do_tick();
    req_check("fwd_wrap", 19);

    do_reset();
    rev = 1'b1;
    do_tick();
    req_check("rev_wrap", 0);

    // clamped speed, then STATIC ignores phase
    do_reset();
    rev   = 1'b0;
    speed = CW'(25);
    do_tick();
    chk("clamp_phase_model", 32'(phase_m), 32'd19);
    req_check("clamp_lin1", 1);
    mode = 2'd2;
    req_check("static10", 10);

    // request changing every cycle never validates
    for (int k = 0; k < 10; k++) begin
      req = CW'((k * 7) % N);
      last_req = (k * 7) % N;
      #1;
      chk("stream_valid", 32'(cvalid), 32'd0);
      step(1);
    end

    // reset mid-stream flushes outputs and phase
    mode = 2'd0;
    req_check("pre_rst", 5);
    rst = 1'b1;
    step(1);
    chk("midrst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("midrst_valid", 32'(cvalid), 32'd0);
    rst = 1'b0;
    phase_m = 0;
    last_req = -1;
    req_check("post_rst", 19);

    // tick in the same cycle as a new request: that request uses the old phase
    speed = CW'(1);
    req  = CW'(5);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(LAT - 1);
    chk("tick_same_rgb", {8'h0, red, green, blue},
        {8'h0, model_rgb(5, phase_m, 0, col_a, col_b)});
    phase_m = (phase_m + 1) % N;
    last_req = 5;
    req_check("tick_after", 12);

`ifdef PAT_GRADIENT_ANIM_GAMMA_EN
    do_reset();
    mode  = 2'd3;
    col_a = 24'h8000FF;
    col_b = 24'h8000FF;
    req_check("gamma_solid", 7);
    chk("gamma_solid_lit", {8'h0, red, green, blue}, 32'h004000FF);
`endif

    // randomized modes, endpoints, speeds, directions and ticks
    for (int it = 0; it < 40; it++) begin
      int nt;
      mode  = 2'($urandom_range(0, 3));
      col_a = 24'($urandom);
      col_b = 24'($urandom);
      speed = CW'($urandom_range(0, 31));
      rev   = 1'($urandom_range(0, 1));
      nt    = int'($urandom_range(0, 3));
      for (int j = 0; j < nt; j++) do_tick();
      req_check("rnd", int'($urandom_range(0, N - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
